// File: rtl/prog_clk_divider_if.sv
// Control/status bundle for prog_clk_divider.
// The master drives the run request and ratio loads; the slave (the divider)
// returns the divided clock, the period-start strobe and the activity flag.
interface prog_clk_divider_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             active;

    modport master (
        output en,
        output div_val,
        output div_load,
        input  clk_out,
        input  tick,
        input  active
    );

    modport slave (
        input  en,
        input  div_val,
        input  div_load,
        output clk_out,
        output tick,
        output active
    );
endinterface

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider.
// Produces a registered divided clock and a period-start strobe in the clk_in
// domain. Ratio reloads and enable/disable only take effect at period
// boundaries, so clk_out never glitches and no started period is cut short.
// Optional build macro PROG_CLK_DIVIDER_ODD_HALF_EN: adds a falling-edge
// flop that stretches the high phase by half a clk_in cycle for odd ratios,
// giving an exact 50% duty.
//
// state | meaning
// IDLE  | stopped, clk_out parked low, counter held at 0
// RUN   | counting periods, en high
// DRAIN | en dropped, finishing the running period before parking
module prog_clk_divider #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic                  clk_in,
    input  logic                  rst,
    prog_clk_divider_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             pos_q, pos_d;
    logic [CNT_W-1:0] div_clamped;
    logic             period_end;
    logic             boundary;
    logic [CNT_W:0]   half;

    // Ratios below 2 cannot form a high and a low phase, so they are raised to 2.
    always_comb begin
        div_clamped = (bus.div_val < DIV_MIN) ? DIV_MIN : bus.div_val;
    end

    // Next state, counter and ratio bookkeeping; ratio changes only at boundaries.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_act_d  = div_act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        period_end = (state_q != IDLE) && (cnt_q == div_act_q - CNT_W'(1));
        boundary   = period_end || ((state_q == IDLE) && bus.en);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = period_end ? '0 : cnt_q + CNT_W'(1);
                if (!bus.en) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                cnt_d = period_end ? '0 : cnt_q + CNT_W'(1);
                if (bus.en) begin
                    state_d = RUN;
                end else if (period_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A load coinciding with a boundary goes straight into the new period.
        if (boundary) begin
            pend_vld_d = 1'b0;
            if (bus.div_load) begin
                div_act_d = div_clamped;
            end else if (pend_vld_q) begin
                div_act_d = pend_q;
            end
        end else if (bus.div_load) begin
            pend_d     = div_clamped;
            pend_vld_d = 1'b1;
        end
    end

    // High-phase length of the upcoming cycle's period and the next clk_out level.
    always_comb begin
`ifdef PROG_CLK_DIVIDER_ODD_HALF_EN
        half = {1'b0, div_act_d} >> 1;
`else
        half = ({1'b0, div_act_d} + (CNT_W+1)'(1)) >> 1;
`endif
        pos_d = (state_d != IDLE) && ({1'b0, cnt_d} < half);
    end

    // State, counter, ratio and registered clock output.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_act_q  <= DIV_RST;
            pend_q     <= DIV_RST;
            pend_vld_q <= 1'b0;
            pos_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_act_q  <= div_act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            pos_q      <= pos_d;
        end
    end

`ifdef PROG_CLK_DIVIDER_ODD_HALF_EN
    logic neg_q;

    // Half-cycle delayed copy of the posedge clock, used to stretch odd ratios.
    always_ff @(negedge clk_in) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    // Odd ratios OR in the delayed copy; even ratios already split evenly.
    always_comb begin
        bus.clk_out = div_act_q[0] ? (pos_q | neg_q) : pos_q;
    end
`else
    // Posedge-only output; odd ratios get the extra cycle in the high phase.
    always_comb begin
        bus.clk_out = pos_q;
    end
`endif

    // Status outputs decoded from the registered state and counter.
    always_comb begin
        bus.active = (state_q != IDLE);
        bus.tick   = (state_q != IDLE) && (cnt_q == '0);
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: directed scenarios followed by random traffic,
// every cycle compared against a period/position reference model.
module tb_prog_clk_divider;

    localparam int CNT_W = 8;
    localparam int DEF   = 5;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;

    always #5 clk_in = ~clk_in;

    prog_clk_divider_if #(.CNT_W(CNT_W)) bus ();

    prog_clk_divider #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    // Reference model: is a period running, where are we in it, what ratio.
    bit    m_run     = 1'b0;
    bit    m_stop    = 1'b0;
    int    m_pos     = 0;
    int    m_n       = DEF;
    int    m_pend    = DEF;
    bit    m_pvld    = 1'b0;
    bit    m_prev_hi = 1'b0;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    string phase  = "init";

    function automatic int half_of(int n);
`ifdef PROG_CLK_DIVIDER_ODD_HALF_EN
        return n / 2;
`else
        return (n + 1) / 2;
`endif
    endfunction

    function automatic bit exp_hi();
        return m_run && (m_pos < half_of(m_n));
    endfunction

    task automatic check1(input string what, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0b expected=%0b (cycle %0d)", phase, what, obs, exp, cyc);
        end
    endtask

    // Apply one posedge worth of inputs to the model.
    task automatic advance(input bit e, input int v, input bit l, input bit r);
        int cl;
        bit last;
        if (r) begin
            m_run  = 1'b0;
            m_stop = 1'b0;
            m_pos  = 0;
            m_n    = DEF;
            m_pvld = 1'b0;
            return;
        end
        cl   = (v < 2) ? 2 : v;
        last = m_run && (m_pos == m_n - 1);
        if (last || (!m_run && e)) begin
            if (l)           m_n = cl;
            else if (m_pvld) m_n = m_pend;
            m_pvld = 1'b0;
        end else if (l) begin
            m_pend = cl;
            m_pvld = 1'b1;
        end
        if (!m_run) begin
            if (e) begin
                m_run  = 1'b1;
                m_pos  = 0;
                m_stop = 1'b0;
            end
        end else if (last) begin
            m_pos = 0;
            if (m_stop && !e) m_run = 1'b0;
            else              m_stop = !e;
        end else begin
            m_pos++;
            m_stop = !e;
        end
    endtask

    task automatic step(input bit e, input int v, input bit l, input bit r);
        bit cur_hi;
        @(posedge clk_in);
        #2;
        if (cyc > 0) begin
`ifdef PROG_CLK_DIVIDER_ODD_HALF_EN
            check1("clk_out", bus.clk_out, (m_n % 2 == 1) ? (exp_hi() | m_prev_hi) : exp_hi());
`else
            check1("clk_out", bus.clk_out, exp_hi());
`endif
            check1("tick",   bus.tick,   m_run && (m_pos == 0));
            check1("active", bus.active, m_run);
        end
        cyc++;
        bus.en       = e;
        bus.div_val  = v[CNT_W-1:0];
        bus.div_load = l;
        rst          = r;
        cur_hi       = exp_hi();
        advance(e, v, l, r);
`ifdef PROG_CLK_DIVIDER_ODD_HALF_EN
        #4;
        if (cyc > 1) check1("clk_out_late", bus.clk_out, cur_hi);
        m_prev_hi = r ? 1'b0 : cur_hi;
`else
        cur_hi = 1'b0;
`endif
    endtask

    task automatic run(input bit e, input int k);
        for (int i = 0; i < k; i++) step(e, 0, 1'b0, 1'b0);
    endtask

    // Keep running with en=e until the model reaches ratio n at position p.
    task automatic wait_pos(input bit e, input int n, input int p);
        bit hit = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (m_run && m_n == n && m_pos == p) begin
                hit = 1'b1;
                break;
            end
            step(e, 0, 1'b0, 1'b0);
        end
        checks++;
        assert (hit) else begin
            errors++;
            $error("FAIL %s/wait observed=timeout expected=n%0d_pos%0d", phase, n, p);
        end
    endtask

    initial begin
        bus.en       = 1'b0;
        bus.div_val  = '0;
        bus.div_load = 1'b0;

        phase = "reset";
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        run(0, 2);

        phase = "default";
        run(1, 16);

        phase = "reload8";
        wait_pos(1, DEF, 1);
        step(1, 8, 1, 0);
        run(1, 20);

        phase = "reload_last_wins";
        wait_pos(1, 8, 1);
        step(1, 8, 1, 0);
        step(1, 3, 1, 0);
        run(1, 12);

        phase = "clamp0";
        step(1, 0, 1, 0);
        run(1, 8);
        phase = "clamp1";
        step(1, 9, 1, 0);
        step(1, 1, 1, 0);
        run(1, 8);

        phase = "drain";
        step(1, 6, 1, 0);
        wait_pos(1, 6, 2);
        run(0, 8);
        run(0, 3);

        phase = "resume";
        wait_pos(1, 6, 2);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        run(1, 12);

        phase = "reset_mid_run";
        wait_pos(1, 6, 2);
        step(1, 9, 1, 0);
        step(1, 0, 0, 1);
        run(1, 14);

        phase = "odd7";
        step(1, 7, 1, 0);
        run(1, 16);
        phase = "even4";
        step(1, 4, 1, 0);
        run(1, 10);

        phase = "random";
        begin
            bit e = 1'b1;
            for (int i = 0; i < 900; i++) begin
                bit l;
                bit r;
                int v;
                if ($urandom_range(0, 11) == 0) e = !e;
                l = ($urandom_range(0, 9) == 0);
                r = ($urandom_range(0, 199) == 0);
                v = int'($urandom_range(0, 12));
                step(e, v, l, r);
            end
        end
        run(0, 30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
